// File: rtl/dense_layer_engine_if.sv
// Streaming/control bundle for dense_layer_engine: start/status, activation
// input, weight-memory read port and result output stream.
interface dense_layer_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WGT_W  = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned N_IN   = 784,
  parameter int unsigned N_OUT  = 32,
  parameter int unsigned AW     = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int unsigned IW     = $clog2(N_OUT)
) ();
  logic                   start;
  logic                   relu_en;
  logic                   busy;
  logic                   done;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   w_rd;
  logic [AW-1:0]          w_addr;
  logic [N_OUT*WGT_W-1:0] w_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_data;
  logic [IW-1:0]          out_idx;
  logic                   out_last;
  logic [IW-1:0]          argmax;

  modport slave (
    input  start, relu_en, in_valid, in_data, w_data, out_ready,
    output busy, done, in_ready, w_rd, w_addr, out_valid, out_data,
           out_idx, out_last, argmax
  );

  modport master (
    output start, relu_en, in_valid, in_data, w_data, out_ready,
    input  busy, done, in_ready, w_rd, w_addr, out_valid, out_data,
           out_idx, out_last, argmax
  );
endinterface

// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: N_IN activations x N_OUT-wide weight rows,
// results streamed per lane with optional ReLU. Optional DENSE_ARGMAX_EN adds argmax.
module dense_layer_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WGT_W  = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned N_IN   = 784,
  parameter int unsigned N_OUT  = 32,
  parameter int unsigned AW     = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int unsigned IW     = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  dense_layer_engine_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // One extra bit so the counter can represent N_IN itself.
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW-1:0] N_IN_C  = CW'(N_IN);
  localparam logic [CW-1:0] LAST_IN = CW'(N_IN - 1);
  localparam logic [IW-1:0] LAST_LN = IW'(N_OUT - 1);

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            lane_q, lane_d;
  logic signed [DATA_W-1:0] act_q, act_d;
  logic                     mac_pend_q, mac_pend_d;
  logic                     relu_q, relu_d;
  logic signed [ACC_W-1:0]  acc_q [N_OUT];
  logic signed [ACC_W-1:0]  acc_d [N_OUT];
  logic signed [ACC_W-1:0]  prod  [N_OUT];
  logic signed [WGT_W-1:0]  w_lane [N_OUT];

  logic                     accept;
  logic                     in_ready;
  logic                     out_hs;
  logic signed [ACC_W-1:0]  cur_acc;
  logic signed [ACC_W-1:0]  out_val;

  assign in_ready = (state_q == S_LOAD) && (cnt_q < N_IN_C);
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = (state_q == S_DRAIN) && bus.out_ready;
  assign cur_acc  = acc_q[lane_q];
  assign out_val  = (state_q != S_DRAIN)          ? '0 :
                    (relu_q && cur_acc[ACC_W-1])   ? '0 : cur_acc;

  // Weight row arrives the cycle after the accept, aligned with act_q.
  always_comb begin
    for (int unsigned k = 0; k < N_OUT; k++) begin
      w_lane[k] = bus.w_data[k*WGT_W +: WGT_W];
      prod[k]   = ACC_W'(act_q * w_lane[k]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    act_d      = act_q;
    relu_d     = relu_q;
    mac_pend_d = 1'b0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      acc_d[k] = mac_pend_q ? acc_q[k] + prod[k] : acc_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          lane_d  = '0;
          relu_d  = bus.relu_en;
          for (int unsigned k = 0; k < N_OUT; k++) acc_d[k] = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          act_d      = bus.in_data;
          mac_pend_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_IN) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DRAIN;
      default: begin
        if (bus.out_ready) begin
          if (lane_q == LAST_LN) begin
            state_d = S_IDLE;
            lane_d  = '0;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lane_q     <= '0;
      act_q      <= '0;
      mac_pend_q <= 1'b0;
      relu_q     <= 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) acc_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      act_q      <= act_d;
      mac_pend_q <= mac_pend_d;
      relu_q     <= relu_d;
      for (int unsigned k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.w_rd      = accept;
  assign bus.w_addr    = cnt_q[AW-1:0];
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_data  = out_val;
  assign bus.out_idx   = (state_q == S_DRAIN) ? lane_q : '0;
  assign bus.out_last  = (state_q == S_DRAIN) && (lane_q == LAST_LN);
  assign bus.done      = out_hs && (lane_q == LAST_LN);

`ifdef DENSE_ARGMAX_EN
  logic signed [ACC_W-1:0] max_q, max_d;
  logic [IW-1:0]           amax_q, amax_d;

  // Output is the next-state value so the winner is visible during done.
  always_comb begin
    max_d  = max_q;
    amax_d = amax_q;
    if ((state_q == S_IDLE) && bus.start) begin
      max_d  = '0;
      amax_d = '0;
    end else if (out_hs && ((lane_q == '0) || (out_val > max_q))) begin
      max_d  = out_val;
      amax_d = lane_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q  <= '0;
      amax_q <= '0;
    end else begin
      max_q  <= max_d;
      amax_q <= amax_d;
    end
  end

  assign bus.argmax = amax_d;
`else
  assign bus.argmax = '0;
`endif

endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Parametrised fully-connected layer engine; successor to the fixed 32-lane and 10-lane systolic MAC stages of the MNIST accelerator. Consumes a stream of N_IN signed activations and fetches one N_OUT-wide weight row per activation from weight memory. Accumulates N_OUT dot products in parallel, then streams the results out one lane at a time, with optional ReLU applied per run. The same RTL serves both the hidden layer and the output layer, chained through the streaming ports.

## Interface
Parameters:
- DATA_W, 8: activation width, signed.
- WGT_W, 8: weight width, signed.
- ACC_W, 32: accumulator and output width, signed.
- N_IN, 784: activations per run; must be ≥ 1.
- N_OUT, 32: output lanes; must be ≥ 2.
- AW, $clog2(N_IN): width of the weight address.
- IW, $clog2(N_OUT): width of the lane index.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a run; honoured only in IDLE.
- relu_en, in, 1: sampled when start is accepted; applies ReLU to outputs.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse at the end of a run.
- in_valid, in, 1: activation valid.
- in_ready, out, 1: engine can accept an activation.
- in_data, in, DATA_W: activation.
- w_rd, out, 1: weight read strobe.
- w_addr, out, AW: weight row index.
- w_data, in, N_OUT*WGT_W: weight row; lane k occupies bits [k*WGT_W +: WGT_W].
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, ACC_W: result value.
- out_idx, out, IW: lane index of the current result.
- out_last, out, 1: high with lane N_OUT-1.
- argmax, out, IW: winning lane index (only with DENSE_ARGMAX_EN).

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE → LOAD when start is high. On that edge: all accumulators cleared, input counter cnt = 0, relu_en latched.
- LOAD:
  - in_ready = (cnt < N_IN).
  - An accept is in_valid && in_ready. On an accept: w_rd = 1 and w_addr = cnt, both combinational from cnt; in_data registered into act_q; mac_pend set; cnt incremented.
  - Cycle after an accept: acc[k] += sext(act_q) * sext(w_lane[k]) for every k. Products are sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W; no saturation.
  - Gaps in in_valid insert idle cycles. No MAC occurs without a preceding accept.
- LOAD → FLUSH on the accept with cnt == N_IN-1. FLUSH performs the final MAC. FLUSH → DRAIN unconditionally.
- DRAIN:
  - out_valid = 1; out_idx = lane counter; out_data = acc[out_idx].
  - If relu_en was latched and acc[out_idx] < 0, out_data = 0.
  - out_last = (out_idx == N_OUT-1).
  - Lane counter advances only when out_valid && out_ready.
  - out_data and out_idx hold stable while out_ready is low.
- On the last-lane handshake: → IDLE and done pulses for that one cycle.
- start asserted outside IDLE is ignored. start held high through done begins a new run on the IDLE cycle.
- Reset values: state IDLE; accumulators, cnt, lane counter, act_q, mac_pend, argmax all 0; every output 0.
- Reset asserted mid-run aborts immediately: no done, no out_valid.

## Timing
- start accepted at edge t → in_ready high in cycle t+1.
- Weight memory latency is exactly 1 cycle: w_data sampled in the cycle after w_rd.
- Throughput: one activation per cycle with in_valid continuously high.
- Final accept in cycle a → FLUSH MAC in cycle a+1 → out_valid first high in cycle a+2.
- Minimum run length: 1 + N_IN + 1 + N_OUT cycles, from the start cycle through done.
- done is coincident with the final output handshake cycle.

## Configuration
- Macro: DENSE_ARGMAX_EN.
- Defined:
  - A running max compares each output value as presented (post-ReLU) during DRAIN handshakes.
  - Strictly-greater comparison, so ties resolve to the lowest index.
  - argmax is updated so it is valid on the cycle done is high, and holds until the next start.
  - argmax is cleared on start.
- Undefined: argmax port tied to 0; no comparator logic.

## Test plan
- N_IN=4, N_OUT=3; inputs 1,2,3,4; weights lane0=1, lane1=-1, lane2=2 for all rows; relu_en=1 → outputs 10, 0, 20 with out_last on idx 2; argmax=2; done one cycle.
- Same stimulus with relu_en=0 → outputs 10, -10, 20; argmax=2.
- in_valid low on alternate cycles and out_ready low 3 cycles on idx 1 → identical values; out_data and out_idx held while stalled; no MAC on gap cycles.
- All lanes weight 5, inputs 1,1,1,1 → outputs 20, 20, 20; argmax=0 (tie rule).
- reset pulsed low after 2 accepts → all outputs 0, state IDLE; new run with inputs 1,2,3,4 → 10, 0, 20 (no stale accumulation).
- start pulsed during LOAD and DRAIN → ignored; start held through done → second run begins the next cycle with accumulators cleared.
